iddrx2_word_aligner: RTL and testbench

- Receive-side stage directly downstream of an IDDRX2F input DDR primitive; consumes its 4-bit-per-SCLK parallel output (Q0..Q3).
- Assembles the bit stream into 8-bit words and locks word alignment by bit-slipping against a known training pattern.
- Reports lock status.
- Sits between the IOL input gearing and fabric consumers; runs in the SCLK domain produced by CLKDIVF.

---
 rtl/iddrx2_aligner_pkg.sv | 10 +
 rtl/iddrx2_gearbox_4to8.sv | 31 +++
 rtl/iddrx2_word_aligner.sv | 149 ++++++++++++++
 tb/tb_iddrx2_word_aligner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/iddrx2_aligner_pkg.sv
// Shared types and widths for the IDDRX2F word aligner.
package iddrx2_aligner_pkg;

  localparam int WORD_W = 8;
  localparam int NIB_W  = 4;
  localparam int SLIP_W = 3;

  typedef enum logic [1:0] {HUNT, WAIT, CHECK, LOCKED} aligner_state_e;

endpackage

// File: rtl/iddrx2_gearbox_4to8.sv
// 4-to-8 gearbox: nibble history, word phase and bit-offset window select.
module iddrx2_gearbox_4to8
  import iddrx2_aligner_pkg::*;
(
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  din,
  input  logic [SLIP_W-1:0] slip_pos,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  // hist[0] is the oldest bit; the newest nibble enters at the top
  logic [2*WORD_W-1:0] hist;
  logic                phase;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hist       <= '0;
      phase      <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      hist       <= {din, hist[2*WORD_W-1:NIB_W]};
      phase      <= ~phase;
      word_valid <= phase;
      if (phase) word_out <= hist[slip_pos +: WORD_W];
    end
  end

endmodule

// File: rtl/iddrx2_word_aligner.sv
// Word aligner behind IDDRX2F: bit-slips until TRAIN_PATTERN is seen, tracks lock.
// Optional ALIGNER_STATS_EN adds a saturating slip_count port.
module iddrx2_word_aligner
  import iddrx2_aligner_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'h1E,
  parameter int unsigned       LOCK_COUNT    = 4,
  parameter int unsigned       ERR_COUNT     = 3,
  parameter int unsigned       SLIP_WAIT     = 2
)(
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  din,
  input  logic              train_en,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic [SLIP_W-1:0] slip_pos,
  output logic              align_err
`ifdef ALIGNER_STATS_EN
  ,output logic [15:0]      slip_count
`endif
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_N  = 4'(ERR_COUNT);
  localparam logic [2:0] WAIT_N = 3'(SLIP_WAIT);

  aligner_state_e    state_q, state_d;
  logic [3:0]        match_q, match_d, err_q, err_d;
  logic [2:0]        wait_q, wait_d;
  logic [SLIP_W-1:0] slip_d;
  logic              locked_d, align_err_d, slip_go, cmp;

  iddrx2_gearbox_4to8 u_gearbox (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .din        (din),
    .slip_pos   (slip_pos),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  assign cmp = (word_out == TRAIN_PATTERN);

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    err_d       = err_q;
    wait_d      = wait_q;
    slip_d      = slip_pos;
    locked_d    = locked;
    align_err_d = 1'b0;
    slip_go     = 1'b0;
    if (word_valid) begin
      case (state_q)
        HUNT: if (train_en) begin
          if (cmp) begin
            match_d = 4'd1;
            if (LOCK_N == 4'd1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              err_d    = '0;
            end else begin
              state_d = CHECK;
            end
          end else begin
            slip_go = 1'b1;
          end
        end
        // words in flight still carry the old offset's alignment history
        WAIT: if (wait_q <= 3'd1) begin
          wait_d  = '0;
          state_d = HUNT;
        end else begin
          wait_d = wait_q - 3'd1;
        end
        CHECK: if (!train_en) begin
          state_d = HUNT;
          match_d = '0;
        end else if (cmp) begin
          if (match_q + 4'd1 >= LOCK_N) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            match_d  = '0;
            err_d    = '0;
          end else begin
            match_d = match_q + 4'd1;
          end
        end else begin
          match_d = '0;
          slip_go = 1'b1;
        end
        // with train_en low the link carries payload, so lock is held blindly
        LOCKED: if (train_en) begin
          if (cmp) begin
            err_d = '0;
          end else if (err_q + 4'd1 >= ERR_N) begin
            state_d     = HUNT;
            locked_d    = 1'b0;
            align_err_d = 1'b1;
            err_d       = '0;
            match_d     = '0;
          end else begin
            err_d = err_q + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
      if (slip_go) begin
        slip_d = slip_pos + 3'd1;
        if (WAIT_N == 3'd0) begin
          state_d = HUNT;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_N;
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      match_q   <= '0;
      err_q     <= '0;
      wait_q    <= '0;
      slip_pos  <= '0;
      locked    <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      slip_pos  <= slip_d;
      locked    <= locked_d;
      align_err <= align_err_d;
    end
  end

`ifdef ALIGNER_STATS_EN
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)                                slip_count <= '0;
    else if (slip_go && slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_iddrx2_word_aligner.sv
// Directed bench for iddrx2_word_aligner: serial stream generator plus hand-derived checks.
module tb_iddrx2_word_aligner;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       train_en;
  logic [7:0] word_out;
  logic       word_valid, locked, align_err;
  logic [2:0] slip_pos;
`ifdef ALIGNER_STATS_EN
  logic [15:0] slip_count;
`endif

  iddrx2_word_aligner dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .din        (din),
    .train_en   (train_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .slip_pos   (slip_pos),
    .align_err  (align_err)
`ifdef ALIGNER_STATS_EN
    ,.slip_count (slip_count)
`endif
  );

  always #5 sclk = ~sclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // posedges since reset release
  int pe;
  always @(posedge sclk or negedge rst_n)
    if (!rst_n) pe <= 0;
    else        pe <= pe + 1;

  // Serial stream: even edges carry the low nibble of a word, odd edges the high.
  logic [7:0] base_word = 8'h00;
  logic [7:0] cur       = 8'h00;
  logic [7:0] pq[$];
  logic [7:0] sent [0:1023];
  int         nxt_e     = 1;

  always @(negedge sclk) begin
    if (!rst_n) begin
      nxt_e = 1;
      cur   = base_word;
      din   = 4'h0;
    end else begin
      if (nxt_e % 2 == 0) begin
        cur = (pq.size() > 0) ? pq.pop_front() : base_word;
        sent[nxt_e/2] = cur;
        din = cur[3:0];
      end else begin
        din = cur[7:4];
      end
      nxt_e++;
    end
  end

  int         slip_evt   = 0;
  int         err_pulses = 0;
  int         cmp_words  = 0;
  logic [2:0] prev_sp    = 3'd0;

  always @(negedge sclk) begin
    if (rst_n && slip_pos != prev_sp) slip_evt++;
    prev_sp = slip_pos;
    if (rst_n && align_err) err_pulses++;
    if (rst_n && word_valid && train_en && !locked) cmp_words++;
  end

  task automatic do_reset(input logic [7:0] bw);
    train_en  = 1'b0;
    rst_n     = 1'b0;
    base_word = bw;
    repeat (2) @(posedge sclk);
    #2 rst_n = 1'b1;
  endtask

  // raise train_en after the first two (reset-polluted) words have gone by
  task automatic arm_train();
    repeat (5) @(posedge sclk);
    @(negedge sclk);
    train_en = 1'b1;
  endtask

  task automatic wait_lock(input string tag, input int max, input logic want);
    for (int i = 0; i < max; i++) begin
      @(negedge sclk);
      if (locked == want) break;
    end
    chk(tag, locked, want);
  endtask

  task automatic next_word();
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      if (word_valid) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  int         s0, e0, c0, m;
  logic       lost;
  logic [15:0] pair;

  initial begin
    rst_n = 1'b0; train_en = 1'b0; base_word = 8'h00;
    repeat (2) @(posedge sclk);
    #2;
    chk("rst_word", word_out, 8'h00);
    chk("rst_wv", word_valid, 1'b0);
    chk("rst_lock", locked, 1'b0);
    chk("rst_slip", slip_pos, 3'd0);
    chk("rst_err", align_err, 1'b0);
    rst_n = 1'b1;

    // idle zeros: strobe every second cycle starting at cycle 2
    for (int i = 1; i <= 6; i++) begin
      @(posedge sclk); @(negedge sclk);
      chk("a_wv", word_valid, (i % 2 == 0));
      chk("a_word", word_out, 8'h00);
    end
    chk("a_lock", locked, 1'b0);
    chk("a_slip", slip_pos, 3'd0);

    // 8'hF0 stream = pattern rotated by 3: offsets 0,1,2 fail, 3 locks
    do_reset(8'hF0);
    s0 = slip_evt;
    arm_train();
    wait_lock("b_lock", 200, 1'b1);
    chk("b_slips", slip_evt - s0, 3);
    chk("b_slip_pos", slip_pos, 3'd3);
`ifdef ALIGNER_STATS_EN
    chk("b_slip_cnt", slip_count, 16'd3);
`endif
    for (int i = 0; i < 4; i++) begin
      next_word();
      chk("b_word", word_out, 8'h1E);
    end

    // payload while locked: lock held, window fixed at offset 3
    @(negedge sclk);
    train_en = 1'b0;
    e0 = err_pulses;
    for (int i = 0; i < 8; i++) pq.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 12; i++) begin
      next_word();
      m    = pe / 2;
      pair = {sent[m-1], sent[m-2]};
      pair = pair >> 3;
      chk("b_payload", word_out, pair[7:0]);
      chk("b_pay_lock", locked, 1'b1);
    end
    chk("b_pay_slip", slip_pos, 3'd3);
    chk("b_pay_err", err_pulses - e0, 0);

    // aligned stream: exactly 4 compared words to lock, no slips
    do_reset(8'h1E);
    s0 = slip_evt; c0 = cmp_words;
    arm_train();
    wait_lock("d_lock", 100, 1'b1);
    chk("d_words", cmp_words - c0, 4);
    chk("d_slips", slip_evt - s0, 0);
    chk("d_slip_pos", slip_pos, 3'd0);
`ifdef ALIGNER_STATS_EN
    chk("d_slip_cnt", slip_count, 16'd0);
`endif

    // two bad words are tolerated
    e0 = err_pulses; lost = 1'b0;
    pq.push_back(8'h00); pq.push_back(8'h00);
    for (int i = 0; i < 16; i++) begin
      @(negedge sclk);
      if (!locked) lost = 1'b1;
    end
    chk("d_hold", lost, 1'b0);
    chk("d_no_err", err_pulses - e0, 0);

    // three bad words drop lock with a single align_err pulse
    pq.push_back(8'h00); pq.push_back(8'h00); pq.push_back(8'h00);
    wait_lock("d_drop", 60, 1'b0);
    repeat (4) @(negedge sclk);
    chk("d_err_pulse", err_pulses - e0, 1);
    chk("d_drop_slip", slip_pos, 3'd0);
    wait_lock("d_relock", 100, 1'b1);
    chk("d_relock_slip", slip_pos, 3'd0);

    // asynchronous reset while in CHECK at offset 3
    do_reset(8'hF0);
    arm_train();
    for (int i = 0; i < 100; i++) begin
      @(negedge sclk);
      if (slip_pos == 3'd3) break;
    end
    chk("e_reach3", slip_pos, 3'd3);
    repeat (8) @(posedge sclk);
    #2;
    chk("e_prelock", locked, 1'b0);
    chk("e_preword", word_out, 8'h1E);
    rst_n = 1'b0;
    #1;
    chk("e_word", word_out, 8'h00);
    chk("e_wv", word_valid, 1'b0);
    chk("e_slip", slip_pos, 3'd0);
    chk("e_lock", locked, 1'b0);
    do_reset(8'hF0);
    s0 = slip_evt;
    arm_train();
    wait_lock("e_relock", 200, 1'b1);
    chk("e_slips", slip_evt - s0, 3);
    chk("e_slip_pos", slip_pos, 3'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
